tick_decim_accum: RTL and testbench
===================================

// Module: tick_decim_accum
// PURPOSE
//  Tick-driven decimating accumulator for the DAQ sample path. Consumes the
//  one-cycle carry-out pulse of the rate counter as a sample strobe and captures
//  din on each strobe. After M samples it emits one sum (or mean) word on a
//  valid/ready output toward the packer/FIFO. Tracks overruns when downstream stalls.
// PARAMETERS
//  DW       16  input sample width (two's complement if SIGNED=1)
//  M        64  samples per output word; M>=2
//  SIGNED   1   1: sign-extend din; 0: zero-extend
//  MEAN     0   0: output full sum; 1: output sum>>>log2(M) (M must be a power of 2)
//  OCW      8   width of the saturating overrun counter
// PORTS
//  clk         in   1              single clock, posedge only
//  rst_n       in   1              async active-low reset
//  en          in   1              accumulate enable; ticks ignored when low
//  clr         in   1              sync clear of accumulation, output and overrun state
//  tick        in   1              sample strobe (rate-counter co), 1-cycle pulse
//  din         in   DW             sample, valid in the tick cycle
//  dout        out  AW             AW = MEAN ? DW : DW+$clog2(M)
//  dout_valid  out  1              result held stable while valid && !ready
//  dout_ready  in   1              downstream accept
//  sample_idx  out  $clog2(M)      samples captured in the current block, 0..M-1
//  overrun     out  1              sticky: a completed block was dropped
//  ovr_cnt     out  OCW            dropped-block count, saturates at all-ones
// BEHAVIOUR
//  - Reset (async, rst_n=0): acc=0, sample_idx=0, dout=0, dout_valid=0, overrun=0, ovr_cnt=0.
//  - Capture: tick&&en&&!clr && sample_idx<M-1 -> acc+=ext(din), sample_idx++.
//  - Block end: tick&&en&&!clr && sample_idx==M-1 -> result=acc+ext(din),
//    acc<=0, sample_idx<=0 (wrap). Next tick starts a fresh block.
//  - Internal sum width is DW+$clog2(M); it never overflows for M samples.
//  - MEAN=1: dout = arithmetic (SIGNED) or logical shift of the sum by log2(M).
//  - Latency: dout/dout_valid update on the clock edge that samples the final tick,
//    so they are visible in the following cycle.
//  - Handshake: a transfer occurs when dout_valid&&dout_ready at a rising edge; then
//    dout_valid clears unless a new result loads in the same edge.
//  - dout and dout_valid must not change while dout_valid&&!dout_ready, except by clr.
//  - Block end while dout_valid&&!dout_ready: new result discarded, old word kept,
//    overrun<=1, ovr_cnt++ (saturating). Accumulation continues with a fresh block.
//  - Block end while dout_valid&&dout_ready, same edge: new word loads,
//    dout_valid stays 1, no overrun.
//  - en=0: acc and sample_idx hold. The output side (handshake) keeps operating.
//  - clr=1 (priority over tick): acc=0, sample_idx=0, dout_valid=0, overrun=0, ovr_cnt=0.
//    dout value is don't-care.
//  - Reset mid-block: partial sum is lost. The first block after reset is a full M samples.
//  - tick while rst_n=0 or clr=1 is discarded.
//  - No internal FSM beyond the sample counter and the output-register state.
//    The output register has two states: EMPTY (valid=0) and FULL (valid=1).
// STRUCTURE
//  - daq_pkg: function decim_aw(DW,M,MEAN) returning AW, and an SV assertion macro
//    checking the MEAN power-of-2 rule.
//  - Sub-module dec_out_reg #(W): 1-deep valid/ready holding register with
//    load, drop and clr.
//  - dec_out_reg exposes the "dropped" pulse; the top level keeps overrun/ovr_cnt.
//  - Top level holds the extension logic, the accumulator, sample_idx and overrun logic.
//  - Elaboration checks: M>=2; MEAN=1 requires M==2**$clog2(M).
// TESTING
//  1. DW=16,M=4,SIGNED=1, ready=1; ticks with din=1,2,3,4
//     -> dout=10, valid for 1 cycle after the 4th tick; sample_idx back to 0.
//  2. SIGNED=1, din=-32768 x4
//     -> dout=-131072 (18-bit 0x20000). Repeat with MEAN=1 -> dout=-32768.
//  3. ready=0 through two full blocks (1,1,1,1 then 2,2,2,2)
//     -> dout stays 4; overrun=1, ovr_cnt=1. Raise ready -> one transfer, valid=0.
//  4. Final tick on the same edge as a valid&&ready transfer
//     -> new sum loads, valid stays 1, overrun stays 0.
//  5. en=0 after 2 ticks, 5 ticks while disabled, en=1, 2 more ticks
//     -> exactly one output, equal to the sum of the 4 enabled samples.
//  6. Assert rst_n low asynchronously mid-block (sample_idx=2), and separately pulse clr
//     -> all outputs zero immediately, or next edge for clr; the next output needs M fresh ticks.

Source files
------------

// File: rtl/daq_pkg.sv
// Shared helpers for the DAQ decimation path: output-width rule and the
// configuration check used at elaboration time by the decimator.
`ifndef DAQ_PKG_SV
`define DAQ_PKG_SV

// Elaboration-time guard: M>=2, and MEAN needs M to be a power of two.
`define DECIM_CFG_CHECK(m_, mean_) \
  if (!daq_pkg::decim_cfg_ok((m_), (mean_))) begin : g_cfg_err \
    $error("tick_decim_accum: need M>=2, and M a power of 2 when MEAN=1"); \
  end

package daq_pkg;

  // Output word width: full-precision sum, or DW when the mean is taken.
  function automatic int decim_aw(input int dw, input int m, input bit mean);
    return mean ? dw : dw + $clog2(m);
  endfunction

  function automatic bit decim_cfg_ok(input int m, input bit mean);
    if (m < 2) return 1'b0;
    if (mean && (m != (1 << $clog2(m)))) return 1'b0;
    return 1'b1;
  endfunction

endpackage

`endif

// File: rtl/tick_decim_accum_if.sv
// Valid/ready result stream from the decimating accumulator toward the packer/FIFO.
interface tick_decim_accum_if #(
  parameter int W = 18
) ();
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/tick_decim_accum_out_reg.sv
// One-deep valid/ready holding register. A load into a stalled register is
// refused and reported on the single-cycle "dropped" output.
module dec_out_reg #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         dropped
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]   state_reg, state_next;
  logic [W-1:0] data_reg, data_next;
  logic         accept_w, stall_w;

  assign accept_w = (state_reg == ST_FULL) && ready;
  assign stall_w  = (state_reg == ST_FULL) && !ready;
  assign dropped  = load && stall_w && !clr;

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    if (clr) begin
      state_next = ST_EMPTY;
    end else if (load && !stall_w) begin
      // Covers both the empty case and a transfer on the same edge.
      state_next = ST_FULL;
      data_next  = load_data;
    end else if (accept_w) begin
      state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
    end
  end

  assign valid = (state_reg == ST_FULL);
  assign data  = data_reg;

endmodule

// File: rtl/tick_decim_accum.sv
// Tick-driven decimating accumulator: sums M samples captured on rate-counter
// strobes and hands the sum (or mean) downstream, counting dropped blocks.
module tick_decim_accum
  import daq_pkg::*;
#(
  parameter int DW     = 16,
  parameter int M      = 64,
  parameter int SIGNED = 1,
  parameter int MEAN   = 0,
  parameter int OCW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 tick,
  input  logic [DW-1:0]        din,
  tick_decim_accum_if.master   out_if,
  output logic [$clog2(M)-1:0] sample_idx,
  output logic                 overrun,
  output logic [OCW-1:0]       ovr_cnt
);

  localparam int IW = $clog2(M);
  localparam int SW = DW + IW;
  localparam int AW = decim_aw(DW, M, MEAN != 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  `DECIM_CFG_CHECK(M, MEAN != 0)

  logic [SW-1:0]  din_ext;
  logic [SW-1:0]  acc_reg, acc_next, sum_w;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [AW-1:0]  result_w;
  logic           take_w, last_w;
  logic           out_valid_w, dropped_w;
  logic [AW-1:0]  out_data_w;
  logic           overrun_reg, overrun_next;
  logic [OCW-1:0] ovr_cnt_reg, ovr_cnt_next;

  // Widen the sample to the sum width so M samples can never overflow.
  assign din_ext[DW-1:0] = din;
  for (genvar gi = DW; gi < SW; gi++) begin : g_ext
    assign din_ext[gi] = (SIGNED != 0) ? din[DW-1] : 1'b0;
  end

  assign sum_w  = acc_reg + din_ext;
  assign take_w = tick && en && !clr;
  assign last_w = take_w && (idx_reg == LAST_IDX);

  // Dropping the low bits of the full-width sum is the shift by log2(M);
  // sign vs zero fill only affects bits above DW, which are discarded.
  if (MEAN != 0) begin : g_mean
    logic unused_lsbs;
    assign result_w    = sum_w[SW-1:IW];
    assign unused_lsbs = ^sum_w[IW-1:0];
  end else begin : g_sum
    assign result_w = sum_w;
  end

  always_comb begin
    acc_next = acc_reg;
    idx_next = idx_reg;
    if (clr) begin
      acc_next = '0;
      idx_next = '0;
    end else if (take_w) begin
      if (last_w) begin
        acc_next = '0;
        idx_next = '0;
      end else begin
        acc_next = sum_w;
        idx_next = idx_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      idx_reg <= '0;
    end else begin
      acc_reg <= acc_next;
      idx_reg <= idx_next;
    end
  end

  dec_out_reg #(
    .W (AW)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (last_w),
    .load_data (result_w),
    .ready     (out_if.dout_ready),
    .valid     (out_valid_w),
    .data      (out_data_w),
    .dropped   (dropped_w)
  );

  assign out_if.dout       = out_data_w;
  assign out_if.dout_valid = out_valid_w;

  always_comb begin
    overrun_next = overrun_reg;
    ovr_cnt_next = ovr_cnt_reg;
    if (clr) begin
      overrun_next = 1'b0;
      ovr_cnt_next = '0;
    end else if (dropped_w) begin
      overrun_next = 1'b1;
      if (!(&ovr_cnt_reg)) ovr_cnt_next = ovr_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_reg <= 1'b0;
      ovr_cnt_reg <= '0;
    end else begin
      overrun_reg <= overrun_next;
      ovr_cnt_reg <= ovr_cnt_next;
    end
  end

  assign sample_idx = idx_reg;
  assign overrun    = overrun_reg;
  assign ovr_cnt    = ovr_cnt_reg;

endmodule

// File: tb/tb_tick_decim_accum.sv
// Directed bench: a sum-mode and a mean-mode decimator (M=4) share one stimulus.
module tb_tick_decim_accum;

  localparam int DW   = 16;
  localparam int M    = 4;
  localparam int OCW  = 8;
  localparam int AW_S = 18;
  localparam int AW_M = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          tick = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] din = '0;

  logic [1:0]     idx_s, idx_m;
  logic           ovr_s, ovr_m;
  logic [OCW-1:0] cnt_s, cnt_m;

  tick_decim_accum_if #(.W(AW_S)) s_if ();
  tick_decim_accum_if #(.W(AW_M)) m_if ();
  assign s_if.dout_ready = ready;
  assign m_if.dout_ready = ready;

  tick_decim_accum #(.DW(DW), .M(M), .SIGNED(1), .MEAN(0), .OCW(OCW)) u_sum (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .tick(tick), .din(din),
    .out_if(s_if), .sample_idx(idx_s), .overrun(ovr_s), .ovr_cnt(cnt_s)
  );

  tick_decim_accum #(.DW(DW), .M(M), .SIGNED(1), .MEAN(1), .OCW(OCW)) u_mean (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .tick(tick), .din(din),
    .out_if(m_if), .sample_idx(idx_m), .overrun(ovr_m), .ovr_cnt(cnt_m)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tk(input logic [DW-1:0] d);
    tick = 1'b1;
    din  = d;
    step();
    tick = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [AW_S-1:0] exp_s, input logic [AW_M-1:0] exp_m);
    chk({tag, " sum.valid"}, s_if.dout_valid, 1'b1);
    chk({tag, " sum.dout"}, s_if.dout, exp_s);
    chk({tag, " mean.valid"}, m_if.dout_valid, 1'b1);
    chk({tag, " mean.dout"}, m_if.dout, exp_m);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, " sum.valid"}, s_if.dout_valid, 1'b0);
    chk({tag, " mean.valid"}, m_if.dout_valid, 1'b0);
  endtask

  initial begin
    // Reset state, and a tick held across an edge while in reset.
    en = 1'b1; tick = 1'b1; din = 16'd5;
    #2;
    chk("rst dout", s_if.dout, '0);
    chk("rst mean dout", m_if.dout, '0);
    chk_empty("rst");
    chk("rst idx", idx_s, 2'd0);
    chk("rst overrun", ovr_s, 1'b0);
    chk("rst ovr_cnt", cnt_s, '0);
    step();
    tick = 1'b0;
    chk("rst tick idx", idx_s, 2'd0);
    #2 rst_n = 1'b1;
    step();

    // 1: basic sum, one-cycle valid with ready high.
    ready = 1'b1;
    tk(16'd1); tk(16'd2); tk(16'd3);
    chk("t1 idx3", idx_s, 2'd3);
    chk_empty("t1 pre");
    tk(16'd4);
    chk_word("t1", 18'd10, 16'd2);
    chk("t1 idx wrap", idx_s, 2'd0);
    step();
    chk_empty("t1 post");

    // 2: most-negative samples.
    for (int i = 0; i < 4; i++) tk(16'h8000);
    chk_word("t2", 18'h20000, 16'h8000);
    step();
    chk_empty("t2 post");

    // 3: stalled downstream across two blocks.
    ready = 1'b0;
    for (int i = 0; i < 4; i++) tk(16'd1);
    chk_word("t3 first", 18'd4, 16'd1);
    for (int i = 0; i < 4; i++) tk(16'd2);
    chk_word("t3 kept", 18'd4, 16'd1);
    chk("t3 overrun", ovr_s, 1'b1);
    chk("t3 ovr_cnt", cnt_s, 8'd1);
    chk("t3 mean ovr_cnt", cnt_m, 8'd1);
    step();
    chk_word("t3 hold", 18'd4, 16'd1);
    ready = 1'b1;
    step();
    chk_empty("t3 drained");
    chk("t3 overrun sticky", ovr_s, 1'b1);

    // Overrun counter saturation: one block loads, 299 are dropped.
    ready = 1'b0;
    for (int b = 0; b < 300; b++)
      for (int i = 0; i < 4; i++) tk(16'd0);
    chk("sat ovr_cnt", cnt_s, 8'hFF);
    chk("sat mean ovr_cnt", cnt_m, 8'hFF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_empty("clr");
    chk("clr overrun", ovr_s, 1'b0);
    chk("clr ovr_cnt", cnt_s, '0);
    chk("clr idx", idx_s, 2'd0);

    // 4: final tick coincides with a transfer.
    for (int i = 0; i < 4; i++) tk(16'd1);
    chk_word("t4 first", 18'd4, 16'd1);
    tk(16'd5); tk(16'd5); tk(16'd5);
    ready = 1'b1;
    tk(16'd5);
    chk_word("t4 reload", 18'd20, 16'd5);
    chk("t4 overrun", ovr_s, 1'b0);
    step();
    chk_empty("t4 post");

    // 5: enable gating.
    tk(16'd3); tk(16'd4);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tk(16'd100);
      chk_empty("t5 disabled");
    end
    chk("t5 idx held", idx_s, 2'd2);
    en = 1'b1;
    tk(16'd5);
    chk_empty("t5 pre");
    tk(16'd6);
    chk_word("t5", 18'd18, 16'd4);
    step();
    chk_empty("t5 post");

    // 6: asynchronous reset mid-block.
    tk(16'd7); tk(16'd7);
    chk("t6 idx2", idx_s, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async idx", idx_s, 2'd0);
    chk("t6 async dout", s_if.dout, '0);
    chk_empty("t6 async");
    tick = 1'b1; din = 16'd9;
    step();
    tick = 1'b0;
    chk("t6 rst tick idx", idx_s, 2'd0);
    #2 rst_n = 1'b1;
    step();
    tk(16'd1); tk(16'd1); tk(16'd1);
    chk_empty("t6 fresh pre");
    chk("t6 fresh idx", idx_s, 2'd3);
    tk(16'd1);
    chk_word("t6 fresh", 18'd4, 16'd1);

    // 6b: clr wins over a same-cycle tick and empties the output.
    ready = 1'b0;
    tk(16'd9); tk(16'd9);
    chk("t6 clr pre idx", idx_s, 2'd2);
    clr = 1'b1; tick = 1'b1; din = 16'd9;
    step();
    clr = 1'b0; tick = 1'b0;
    chk_empty("t6 clr");
    chk("t6 clr idx", idx_s, 2'd0);
    ready = 1'b1;
    tk(16'd2); tk(16'd2); tk(16'd2);
    chk_empty("t6 clr pre");
    tk(16'd2);
    chk_word("t6 after clr", 18'd8, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
